uart_tx_fifo: RTL
=================

// Module: uart_tx_fifo
// PURPOSE
// - TX buffer directly upstream of uart_core: CPU/swreg writes push bytes; block pops and feeds uart_core one at a time.
// - Drives uart_core tx_data_i/data_write_en_i and watches tx_ready_o, so software can queue DEPTH bytes without polling TXREADY.
// PARAMETERS
// - DATA_W      8  character width; matches UART_DATA_W
// - DEPTH_LOG2  4  FIFO depth = 2**DEPTH_LOG2 = 16 entries
// PORTS
// - clk_i         in   1             clock
// - arst_n_i      in   1             reset, asynchronous, active-low
// - cke_i         in   1             clock enable; 0 freezes all state
// - rst_soft_i    in   1             synchronous flush (SOFTRESET)
// - wdata_i       in   DATA_W        push data
// - wen_i         in   1             push strobe, one entry per cycle high
// - full_o        out  1             level == DEPTH
// - empty_o       out  1             level == 0
// - level_o       out  DEPTH_LOG2+1  entries stored, 0..DEPTH
// - overflow_o    out  1             sticky: push attempted while full
// - tx_en_i       in   1             TXEN; 0 inhibits new issues
// - tx_ready_i    in   1             from uart_core tx_ready_o
// - tx_data_o     out  DATA_W        to uart_core tx_data_i
// - tx_write_en_o out  1             to uart_core data_write_en_i, 1-cycle pulse
// - irq_thresh_i  in   DEPTH_LOG2+1  low-watermark threshold
// - irq_o         out  1             low-watermark interrupt (see CONFIGURATION)
// BEHAVIOUR
// - Async reset (arst_n_i=0): pointers, level, overflow_o, tx_data_o, tx_write_en_o, irq_o = 0; empty_o=1, full_o=0; FSM=IDLE.
// - rst_soft_i=1 (cke_i=1): same values at next edge; overrides push/pop that cycle.
// - Storage: DEPTH x DATA_W regs, rd/wr pointers DEPTH_LOG2 bits, wrap modulo DEPTH.
// - Push: wen_i & !full_o -> write at wr_ptr, wr_ptr++. wen_i & full_o -> data dropped, overflow_o=1. No push-through-full even if a pop happens that cycle.
// - Pop occurs only in LOAD. Push+pop same cycle: level unchanged; both pointers advance.
// - Empty FIFO: pop impossible (LOAD entered only when !empty_o); no bypass path.
// - FSM (registered; moves only when cke_i=1):
//   IDLE: tx_en_i & tx_ready_i & !empty_o -> LOAD.
//   LOAD: tx_data_o <= mem[rd_ptr]; rd_ptr++; level--; -> STROBE.
//   STROBE: tx_write_en_o=1 for exactly this cycle; tx_data_o stable; -> WAIT_BUSY; clear timeout count.
//   WAIT_BUSY: tx_ready_i=0 -> WAIT_DONE; tx_ready_i=1 for 4 consecutive cycles -> IDLE (char treated as consumed).
//   WAIT_DONE: tx_ready_i=1 -> IDLE.
// - Latency: push into empty FIFO with core idle: LOAD 1 cycle after push, strobe 2 cycles after push.
// - tx_data_o holds last issued byte until next LOAD; tx_write_en_o is 0 outside STROBE.
// - tx_en_i drop mid-transfer: current byte completes its FSM sequence; no new IDLE->LOAD while 0.
// - Back-to-back: min 5 cycles between strobes (LOAD, STROBE, >=1 WAIT_BUSY, >=1 WAIT_DONE, IDLE).
// - Arithmetic: level_o = push_ok - pop, no wrap; full_o/empty_o decoded from level_o.
// CONFIGURATION
// - Macro UART_TX_FIFO_IRQ_EN defined: irq_o registered, = (level_o <= irq_thresh_i) & tx_en_i; updates 1 cycle after level change.
// - Undefined: irq_o tied 0; irq_thresh_i ignored; no comparator logic.
// TESTING
// - Reset: arst_n_i=0 mid-STROBE -> tx_write_en_o=0 immediately, empty_o=1, level_o=0, overflow_o=0.
// - Single byte: tx_en=1, ready=1, push 0xA5 -> tx_data_o=0xA5 at cycle+2, one tx_write_en_o pulse; ready 0 then 1 -> IDLE, empty_o=1.
// - Fill: 17 pushes 0x00..0x10 with tx_en=0 -> full_o=1, level_o=16, overflow_o=1; enable -> bytes 0x00..0x0F out in order, 0x10 absent.
// - Wrap: 40 bytes, random ready delays, concurrent push/pop -> output order matches input, level never exceeds 16.
// - Timeout: core keeps tx_ready_i=1 after strobe -> IDLE after 4 WAIT_BUSY cycles, next byte issued.
// - Soft reset with 5 queued bytes mid-WAIT_DONE -> level_o=0, FSM IDLE, no further strobes; with UART_TX_FIFO_IRQ_EN and thresh=2 -> irq_o=1 next cycle.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that issues queued characters to uart_core one at a time.
// The low-watermark interrupt is built only when UART_TX_FIFO_IRQ_EN is defined.
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  cke_i,
  input  logic                  rst_soft_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic                  wen_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  overflow_o,
  input  logic                  tx_en_i,
  input  logic                  tx_ready_i,
  output logic [DATA_W-1:0]     tx_data_o,
  output logic                  tx_write_en_o,
  input  logic [DEPTH_LOG2:0]   irq_thresh_i,
  output logic                  irq_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, LOAD, STROBE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                state_reg, state_next;
  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [DEPTH_LOG2:0]   level_reg, level_next;
  logic                  overflow_reg;
  logic [DATA_W-1:0]     tx_data_reg;
  logic [1:0]            timeout_reg;
  logic                  push_ok, pop, strobe, timeout_clr, timeout_inc;

  assign full_o        = (level_reg == LEVEL_FULL);
  assign empty_o       = (level_reg == '0);
  assign level_o       = level_reg;
  assign overflow_o    = overflow_reg;
  assign tx_data_o     = tx_data_reg;
  assign tx_write_en_o = strobe;
  assign push_ok       = wen_i & ~full_o;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)  state_reg <= IDLE;
    else if (cke_i) state_reg <= rst_soft_i ? IDLE : state_next;
  end

  // A core that never drops ready after a strobe is assumed to have taken the char.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (tx_en_i && tx_ready_i && !empty_o) state_next = LOAD;
      LOAD:      state_next = STROBE;
      STROBE:    state_next = WAIT_BUSY;
      WAIT_BUSY: if (!tx_ready_i)              state_next = WAIT_DONE;
                 else if (timeout_reg == 2'd3) state_next = IDLE;
      WAIT_DONE: if (tx_ready_i) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    pop         = 1'b0;
    strobe      = 1'b0;
    timeout_clr = 1'b0;
    timeout_inc = 1'b0;
    case (state_reg)
      LOAD:      pop = 1'b1;
      STROBE:    begin
                   strobe      = 1'b1;
                   timeout_clr = 1'b1;
                 end
      WAIT_BUSY: timeout_inc = tx_ready_i;
      default:   ;
    endcase
  end

  always_comb begin
    level_next = level_reg;
    if (push_ok && !pop)      level_next = level_reg + LEVEL_ONE;
    else if (!push_ok && pop) level_next = level_reg - LEVEL_ONE;
  end

  always_ff @(posedge clk_i) begin
    if (cke_i && !rst_soft_i && push_ok) mem[wr_ptr_reg] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
      tx_data_reg  <= '0;
      timeout_reg  <= '0;
    end else if (cke_i) begin
      if (rst_soft_i) begin
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
        level_reg    <= '0;
        overflow_reg <= 1'b0;
        tx_data_reg  <= '0;
        timeout_reg  <= '0;
      end else begin
        if (push_ok)         wr_ptr_reg   <= wr_ptr_reg + PTR_ONE;
        if (wen_i && full_o) overflow_reg <= 1'b1;
        if (pop) begin
          rd_ptr_reg  <= rd_ptr_reg + PTR_ONE;
          tx_data_reg <= mem[rd_ptr_reg];
        end
        level_reg <= level_next;
        if (timeout_clr)      timeout_reg <= '0;
        else if (timeout_inc) timeout_reg <= timeout_reg + 2'd1;
      end
    end
  end

`ifdef UART_TX_FIFO_IRQ_EN
  logic irq_reg;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)  irq_reg <= 1'b0;
    else if (cke_i) irq_reg <= rst_soft_i ? 1'b0 : ((level_reg <= irq_thresh_i) & tx_en_i);
  end

  assign irq_o = irq_reg;
`else
  logic unused_irq_thresh;

  assign unused_irq_thresh = ^irq_thresh_i;
  assign irq_o             = 1'b0;
`endif

endmodule
